// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transfer arbiter and its round-robin picker.
package spi_arb_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      XFER,
      DONE,
      GAP
   } arb_state_e;

   // Pointer width for n requesters; never narrower than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module spi_rr_pick
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner_c,
   output logic [PTR_W-1:0]   winner_idx_c,
   output logic               valid_c
);

   localparam int unsigned SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] sum;
   logic [PTR_W-1:0] slot;

   always_comb begin
      winner_c     = '0;
      winner_idx_c = '0;
      valid_c      = 1'b0;
      sum          = '0;
      slot         = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + SUM_W'(i);
         if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
         slot = sum[PTR_W-1:0];
         if (!valid_c && req[slot]) begin
            valid_c        = 1'b1;
            winner_c[slot] = 1'b1;
            winner_idx_c   = slot;
         end
      end
   end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin scheduler sharing one SPI shifter among NUM_REQ requesters.
// Optional XFER watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic                      PCLK,
   input  logic                      PRESET_n,
   input  logic                      spi_en_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] tx_data_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic                      err_o,
   output logic [DATA_W-1:0]         rx_data_o,
   output logic                      busy_o,
   output logic                      send_data_o,
   output logic [DATA_W-1:0]         spi_tx_data_o,
   input  logic                      recieve_data_i,
   input  logic [DATA_W-1:0]         spi_rx_data_i
);

   localparam int unsigned PTR_W = clog2(NUM_REQ);
   localparam int unsigned GAP_W = 8;

   arb_state_e          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    idx_q, idx_d;
   logic                flag_q, flag_d;
   logic [DATA_W-1:0]   rxbuf_q, rxbuf_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
   logic [15:0]         tcnt_q, tcnt_d;
`endif

   logic [NUM_REQ-1:0]  grant_d, done_d;
   logic                err_d, busy_d, send_d;
   logic [DATA_W-1:0]   rx_d, tx_d;

   logic [NUM_REQ-1:0]  pick_oh;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_valid;
   logic [DATA_W-1:0]   tx_bytes [NUM_REQ];

   spi_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req          (req_i),
      .ptr          (ptr_q),
      .winner_c     (pick_oh),
      .winner_idx_c (pick_idx),
      .valid_c      (pick_valid)
   );

   always_comb begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         tx_bytes[r] = tx_data_i[r*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESET_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         idx_q         <= '0;
         flag_q        <= 1'b0;
         rxbuf_q       <= '0;
         gap_q         <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         tcnt_q        <= '0;
`endif
         grant_o       <= '0;
         done_o        <= '0;
         err_o         <= 1'b0;
         rx_data_o     <= '0;
         busy_o        <= 1'b0;
         send_data_o   <= 1'b0;
         spi_tx_data_o <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         idx_q         <= idx_d;
         flag_q        <= flag_d;
         rxbuf_q       <= rxbuf_d;
         gap_q         <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
         tcnt_q        <= tcnt_d;
`endif
         grant_o       <= grant_d;
         done_o        <= done_d;
         err_o         <= err_d;
         rx_data_o     <= rx_d;
         busy_o        <= busy_d;
         send_data_o   <= send_d;
         spi_tx_data_o <= tx_d;
      end
   end

   // Next state plus the next value of every registered output.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      flag_d  = flag_q;
      rxbuf_d = rxbuf_q;
      gap_d   = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
      tcnt_d  = tcnt_q;
`endif
      grant_d = grant_o;
      done_d  = '0;
      err_d   = 1'b0;
      rx_d    = rx_data_o;
      send_d  = 1'b0;
      tx_d    = spi_tx_data_o;

      case (state_q)
         IDLE: begin
            if (spi_en_i && pick_valid) begin
               state_d = START;
               grant_d = pick_oh;
               idx_d   = pick_idx;
               tx_d    = tx_bytes[pick_idx];
               send_d  = 1'b1;
               flag_d  = 1'b0;
            end
         end
         START: begin
            state_d = XFER;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt_d  = '0;
`endif
         end
         XFER: begin
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt_d = tcnt_q + 16'd1;
`endif
            // Losing the bus beats a same-cycle receive strobe.
            if (!spi_en_i) begin
               flag_d  = 1'b1;
               state_d = DONE;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (tcnt_q + 16'd1 == TIMEOUT_CYCLES - 16'd1) begin
               flag_d  = 1'b1;
               state_d = DONE;
            end
`endif
            else if (recieve_data_i) begin
               rxbuf_d = spi_rx_data_i;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = grant_o;
            err_d   = flag_q;
            if (!flag_q) rx_d = rxbuf_q;
            grant_d = '0;
            ptr_d   = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
            gap_d   = GAP_W'(GAP_CYCLES);
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (gap_q <= GAP_W'(1)) state_d = IDLE;
            else gap_d = gap_q - GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: timestamp-based reference model plus directed tests.
module tb_spi_xfer_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int GAP = 2;
   localparam int TMO = 16;

   logic            PCLK = 1'b0;
   logic            PRESET_n;
   logic            spi_en_i;
   logic [N-1:0]    req_i;
   logic [N*W-1:0]  tx_data_i;
   logic [N-1:0]    grant_o, done_o;
   logic            err_o, busy_o, send_data_o;
   logic [W-1:0]    rx_data_o, spi_tx_data_o;
   logic            recieve_data_i;
   logic [W-1:0]    spi_rx_data_i;

   int errors = 0;
   int checks = 0;

   always #5 PCLK = ~PCLK;

   spi_xfer_arbiter #(
      .NUM_REQ        (N),
      .DATA_W         (W),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (16'd16)
   ) dut (
      .PCLK           (PCLK),
      .PRESET_n       (PRESET_n),
      .spi_en_i       (spi_en_i),
      .req_i          (req_i),
      .tx_data_i      (tx_data_i),
      .grant_o        (grant_o),
      .done_o         (done_o),
      .err_o          (err_o),
      .rx_data_o      (rx_data_o),
      .busy_o         (busy_o),
      .send_data_o    (send_data_o),
      .spi_tx_data_o  (spi_tx_data_o),
      .recieve_data_i (recieve_data_i),
      .spi_rx_data_i  (spi_rx_data_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the owner and the edge numbers of grant, end and gap expiry.
   int         cyc = 0;
   int         m_owner = -1;
   int         m_ptr = 0;
   int         m_grant_edge = 0;
   int         m_end_edge = -1;
   int         m_idle_from = 0;
   bit         m_err = 0;
   logic [7:0] m_rxbuf = '0;
   logic [3:0] e_grant = '0, e_done = '0;
   logic       e_err = 0, e_busy = 0, e_send = 0;
   logic [7:0] e_rx = '0, e_tx = '0;

   task automatic model_step();
      cyc++;
      e_done = '0;
      e_err  = 1'b0;
      e_send = 1'b0;
      if (!PRESET_n) begin
         e_grant = '0; e_rx = '0; e_busy = 1'b0; e_tx = '0;
         m_ptr = 0; m_owner = -1; m_end_edge = -1; m_idle_from = 0;
         return;
      end
      if (m_owner < 0) begin
         if (cyc >= m_idle_from && spi_en_i && req_i != '0) begin
            for (int i = 0; i < N; i++) begin
               if (m_owner < 0 && req_i[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
            end
            m_grant_edge = cyc;
            m_end_edge   = -1;
            e_grant      = 4'(1 << m_owner);
            e_tx         = tx_data_i[m_owner*W +: W];
            e_send       = 1'b1;
         end
      end else if (m_end_edge < 0) begin
         if (cyc >= m_grant_edge + 2) begin
            if (!spi_en_i) begin
               m_end_edge = cyc; m_err = 1;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (cyc - (m_grant_edge + 1) == TMO - 1) begin
               m_end_edge = cyc; m_err = 1;
            end
`endif
            else if (recieve_data_i) begin
               m_end_edge = cyc; m_err = 0; m_rxbuf = spi_rx_data_i;
            end
         end
      end else if (cyc == m_end_edge + 1) begin
         e_done = 4'(1 << m_owner);
         e_err  = m_err;
         if (!m_err) e_rx = m_rxbuf;
         e_grant     = '0;
         m_ptr       = (m_owner + 1) % N;
         m_owner     = -1;
         m_idle_from = cyc + GAP + 1;
      end
      e_busy = (m_owner >= 0) || (cyc < m_idle_from - 1);
   endtask

   initial begin
      forever begin
         @(posedge PCLK);
         model_step();
         #1;
         chk("m grant", 32'(grant_o), 32'(e_grant));
         chk("m done", 32'(done_o), 32'(e_done));
         chk("m err", 32'(err_o), 32'(e_err));
         chk("m rx", 32'(rx_data_o), 32'(e_rx));
         chk("m busy", 32'(busy_o), 32'(e_busy));
         chk("m send", 32'(send_data_o), 32'(e_send));
         chk("m tx", 32'(spi_tx_data_o), 32'(e_tx));
      end
   end

   // Stimulus side: all inputs change just after a falling edge.
   int         sh_lat = 0;
   int         sh_cnt = 0;
   logic [7:0] sh_byte = 8'h10;

   task automatic step();
      @(negedge PCLK);
      recieve_data_i = 1'b0;
      if (sh_cnt > 0) begin
         sh_cnt--;
         if (sh_cnt == 0) begin
            recieve_data_i = 1'b1;
            spi_rx_data_i  = sh_byte;
            sh_byte        = sh_byte + 8'd1;
         end
      end else if (sh_lat > 0 && send_data_o) begin
         sh_cnt = sh_lat;
      end
   endtask

   // which: 0 = send_data_o, 1 = any done_o, 2 = busy_o low
   task automatic wait_sig(input string name, input int which, input int budget, output int n);
      bit hit;
      n = 0;
      hit = 0;
      while (!hit && n < budget) begin
         step();
         n++;
         case (which)
            0:       hit = send_data_o;
            1:       hit = (done_o != '0);
            default: hit = !busy_o;
         endcase
      end
      if (!hit) chk({name, " timeout"}, 32'd0, 32'd1);
   endtask

   function automatic int oh2idx(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return i;
      return -1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         n;
      int         lows;
      int         exp_order [5];
      logic [7:0] fb [4];
      exp_order = '{0, 1, 2, 3, 0};
      fb        = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

      PRESET_n       = 1'b0;
      spi_en_i       = 1'b1;
      req_i          = '0;
      tx_data_i      = {8'h44, 8'h33, 8'hA5, 8'h11};
      recieve_data_i = 1'b0;
      spi_rx_data_i  = '0;
      repeat (3) step();
      chk("rst grant", 32'(grant_o), 32'h0);
      chk("rst busy", 32'(busy_o), 32'h0);
      chk("rst send", 32'(send_data_o), 32'h0);
      chk("rst rx", 32'(rx_data_o), 32'h0);
      PRESET_n = 1'b1;
      step();

      // Single request
      req_i = 4'b0010;
      wait_sig("t1 send", 0, 10, n);
      chk("t1 send latency", n, 1);
      chk("t1 grant", 32'(grant_o), 32'h2);
      chk("t1 tx", 32'(spi_tx_data_o), 32'hA5);
      step();
      chk("t1 send one cycle", 32'(send_data_o), 32'h0);
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'h3C;
      wait_sig("t1 done", 1, 10, n);
      chk("t1 done latency", n, 2);
      chk("t1 done", 32'(done_o), 32'h2);
      chk("t1 rx", 32'(rx_data_o), 32'h3C);
      chk("t1 err", 32'(err_o), 32'h0);
      req_i = '0;

      // Stray strobes in GAP then IDLE
      step();
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'h99;
      step();
      step();
      chk("stray gap done", 32'(done_o), 32'h0);
      chk("stray gap rx", 32'(rx_data_o), 32'h3C);
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'h77;
      step();
      step();
      chk("stray idle done", 32'(done_o), 32'h0);
      chk("stray idle rx", 32'(rx_data_o), 32'h3C);
      chk("stray idle busy", 32'(busy_o), 32'h0);

      // Fairness from a fresh pointer
      PRESET_n = 1'b0;
      step();
      PRESET_n  = 1'b1;
      tx_data_i = {fb[3], fb[2], fb[1], fb[0]};
      sh_lat    = 4;
      req_i     = 4'hF;
      for (int i = 0; i < 5; i++) begin
         wait_sig("fair send", 0, 30, n);
         if (i > 0) chk("fair gap", n - 1, GAP);
         chk("fair order", oh2idx(grant_o), exp_order[i]);
         chk("fair tx", 32'(spi_tx_data_o), 32'(fb[exp_order[i]]));
         wait_sig("fair done", 1, 30, n);
         chk("fair rx", 32'(rx_data_o), 32'(8'h10 + 8'(i)));
         if (i == 4) req_i = '0;
      end
      sh_lat = 0;
      wait_sig("fair idle", 2, 10, n);

      // Abort with a same-cycle receive strobe
      req_i = 4'b0100;
      wait_sig("ab send", 0, 10, n);
      chk("ab grant", 32'(grant_o), 32'h4);
      step();
      spi_en_i       = 1'b0;
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'hEE;
      step();
      spi_en_i = 1'b1;
      wait_sig("ab done", 1, 10, n);
      chk("ab done", 32'(done_o), 32'h4);
      chk("ab err", 32'(err_o), 32'h1);
      chk("ab rx held", 32'(rx_data_o), 32'h14);
      req_i = '0;
      wait_sig("ab idle", 2, 10, n);
      req_i = 4'b0101;
      wait_sig("ab next send", 0, 10, n);
      chk("ab ptr advanced", 32'(grant_o), 32'h1);
      step();
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'h5A;
      wait_sig("ab next done", 1, 10, n);
      chk("ab next rx", 32'(rx_data_o), 32'h5A);
      chk("ab next err", 32'(err_o), 32'h0);
      req_i = '0;
      wait_sig("ab next idle", 2, 10, n);

      // Missing receive strobe
      req_i = 4'b1000;
      wait_sig("to send", 0, 10, n);
`ifdef SPI_ARB_TIMEOUT_EN
      wait_sig("to done", 1, 40, n);
      chk("to latency", n, 17);
      chk("to err", 32'(err_o), 32'h1);
      chk("to done", 32'(done_o), 32'h8);
      chk("to rx held", 32'(rx_data_o), 32'h5A);
`else
      lows = 0;
      repeat (1000) begin
         step();
         if (!busy_o || done_o != '0) lows++;
      end
      chk("hang busy", lows, 0);
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'h61;
      wait_sig("hang done", 1, 10, n);
      chk("hang rx", 32'(rx_data_o), 32'h61);
`endif
      req_i = '0;
      wait_sig("to idle", 2, 10, n);

      // Reset in the middle of a transfer
      req_i = 4'b0001;
      wait_sig("rs pre send", 0, 10, n);
      step();
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'h21;
      wait_sig("rs pre done", 1, 10, n);
      req_i = '0;
      wait_sig("rs pre idle", 2, 10, n);
      req_i = 4'b0100;
      wait_sig("rs send", 0, 10, n);
      chk("rs grant", 32'(grant_o), 32'h4);
      step();
      step();
      PRESET_n = 1'b0;
      step();
      chk("rs grant clr", 32'(grant_o), 32'h0);
      chk("rs done", 32'(done_o), 32'h0);
      chk("rs busy", 32'(busy_o), 32'h0);
      chk("rs rx", 32'(rx_data_o), 32'h0);
      chk("rs tx", 32'(spi_tx_data_o), 32'h0);
      PRESET_n = 1'b1;
      req_i    = 4'hF;
      wait_sig("rs next send", 0, 10, n);
      chk("rs ptr zero", 32'(grant_o), 32'h1);
      step();
      recieve_data_i = 1'b1;
      spi_rx_data_i  = 8'h42;
      wait_sig("rs next done", 1, 10, n);
      chk("rs next done", 32'(done_o), 32'h1);
      req_i = '0;
      wait_sig("rs idle", 2, 10, n);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
